simple3_sweep_ctrl: RTL and testbench



---
 rtl/simple3_sweep_ctrl_pkg.sv | 40 ++++
 rtl/simple3_settle_timer.sv | 28 ++
 rtl/simple3_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_simple3_sweep_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple3_sweep_ctrl_pkg.sv
// Shared types and constants for the 3-input sweep sequencer.
package simple3_sweep_ctrl_pkg;

  localparam int unsigned DEF_NUM_IN = 3;
  localparam int unsigned DEF_SETTLE = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Known 3-input circuits and their expected truth tables (bit i = Z for input i).
  typedef enum logic [1:0] {
    CIRC_MAJ3 = 2'd0,
    CIRC_AND3 = 2'd1,
    CIRC_OR3  = 2'd2,
    CIRC_XOR3 = 2'd3
  } circ_t;

  localparam logic [7:0] EXP_MAJ3 = 8'hE8;
  localparam logic [7:0] EXP_AND3 = 8'h80;
  localparam logic [7:0] EXP_OR3  = 8'hFE;
  localparam logic [7:0] EXP_XOR3 = 8'h96;

  // Look up the expected truth table for a named circuit.
  function automatic logic [7:0] exp_table_of(input circ_t circ);
    logic [7:0] tbl;
    case (circ)
      CIRC_MAJ3: tbl = EXP_MAJ3;
      CIRC_AND3: tbl = EXP_AND3;
      CIRC_OR3:  tbl = EXP_OR3;
      default:   tbl = EXP_XOR3;
    endcase
    return tbl;
  endfunction

endpackage

// File: rtl/simple3_settle_timer.sv
// Loadable down-counter; tc_c flags the last settle cycle (count == 1).
module simple3_settle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Load takes priority over decrement; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == W'(1));

endmodule

// File: rtl/simple3_sweep_ctrl.sv
// Exhaustive input sweep of a small combinational block with truth-table check.
module simple3_sweep_ctrl
  import simple3_sweep_ctrl_pkg::*;
#(
  parameter int unsigned               NUM_IN    = DEF_NUM_IN,
  parameter int unsigned               SETTLE    = DEF_SETTLE,
  parameter logic [(1<<NUM_IN)-1:0]    EXP_TABLE = EXP_MAJ3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [NUM_IN-1:0]        abc_out,
  input  logic                     z_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_IN:0]          err_count,
  output logic [NUM_IN-1:0]        first_fail_idx,
  output logic [(1<<NUM_IN)-1:0]   captured
);

  localparam int unsigned N_VEC = 1 << NUM_IN;
  localparam int unsigned EW    = NUM_IN + 1;
  localparam int unsigned CW    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  state_t              state, state_n;
  logic [NUM_IN-1:0]   idx, idx_n;
  logic [NUM_IN-1:0]   abc_n;
  logic                busy_n, done_n, pass_n;
  logic [EW-1:0]       err_n;
  logic [NUM_IN-1:0]   ffi_n;
  logic [N_VEC-1:0]    cap_n;
  logic                mismatch;
  logic                tmr_load, tmr_dec, tmr_tc_c;

  simple3_settle_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (CW'(SETTLE)),
    .tc_c     (tmr_tc_c)
  );

  // State and result registers; rst wins over everything, including start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      abc_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      captured       <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      abc_out        <= abc_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_fail_idx <= ffi_n;
      captured       <= cap_n;
    end
  end

  // Next-state and next-output logic; z_in only reaches registers, never ports.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    abc_n    = abc_out;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_count;
    ffi_n    = first_fail_idx;
    cap_n    = captured;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    mismatch = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_APPLY;
          idx_n   = '0;
          err_n   = '0;
          ffi_n   = '0;
          cap_n   = '0;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      ST_APPLY: begin
        abc_n    = idx;
        tmr_load = 1'b1;
        state_n  = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
      end
      ST_WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_tc_c) begin
          state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        cap_n[idx] = z_in;
        mismatch   = (z_in != EXP_TABLE[idx]);
        if (mismatch) begin
          err_n = err_count + EW'(1);
          if (err_count == '0) begin
            ffi_n = idx;
          end
        end
        if (idx == NUM_IN'(N_VEC - 1)) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          idx_n   = idx + NUM_IN'(1);
          state_n = ST_APPLY;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_simple3_sweep_ctrl.sv
// Scoreboard bench: drivers push expected sweep results, monitors check on done.
module tb_simple3_sweep_ctrl;

  localparam logic [7:0] EXP_TBL = 8'hE8;

  typedef struct {
    logic [7:0] cap;
    logic [3:0] err;
    logic [2:0] ffi;
    logic       pass;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] abc_a, abc_b;
  logic       z_a, z_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
  logic [2:0] ffi_a, ffi_b;
  logic [7:0] cap_a, cap_b;
  logic [7:0] tt_a = 8'h00, tt_b = 8'h00;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The block under sweep is the truth table held in tt_*.
  assign z_a = tt_a[abc_a];
  assign z_b = tt_b[abc_b];

  simple3_sweep_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abc_out(abc_a), .z_in(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_idx(ffi_a), .captured(cap_a)
  );

  simple3_sweep_ctrl #(.SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abc_out(abc_b), .z_in(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_idx(ffi_b), .captured(cap_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Majority truth table from the definition: at least two of A,B,C high.
  function automatic logic [7:0] maj_tt();
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      t[i] = (int'(v[2]) + int'(v[1]) + int'(v[0])) >= 2;
    end
    return t;
  endfunction

  // Reference result of one complete sweep against the expected table.
  function automatic exp_t model(input logic [7:0] tt, input int start_edge, input int settle);
    exp_t m;
    int   n;
    bit   found;
    n = 0;
    found = 0;
    m.ffi = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (tt[i] != EXP_TBL[i]) begin
        n++;
        if (!found) m.ffi = 3'(i);
        found = 1;
      end
    end
    m.cap      = tt;
    m.err      = 4'(n);
    m.pass     = (n == 0);
    m.done_cyc = start_edge + 8 * (settle + 2);
    return m;
  endfunction

  // Monitor for the SETTLE=2 instance.
  always @(negedge clk) begin
    if (!rst && done_a && !prev_done_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'(done_a), 32'(0));
      end else begin
        e_a = q_a.pop_front();
        chk("a_captured", 32'(cap_a), 32'(e_a.cap));
        chk("a_err_count", 32'(err_a), 32'(e_a.err));
        chk("a_first_fail", 32'(ffi_a), 32'(e_a.ffi));
        chk("a_pass", 32'(pass_a), 32'(e_a.pass));
        chk("a_abc_last", 32'(abc_a), 32'(7));
        chk("a_busy_at_done", 32'(busy_a), 32'(0));
        chk("a_done_cycle", 32'(cyc), 32'(e_a.done_cyc));
      end
    end
    prev_done_a = done_a;
  end

  // Monitor for the SETTLE=0 instance.
  always @(negedge clk) begin
    if (!rst && done_b && !prev_done_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'(done_b), 32'(0));
      end else begin
        e_b = q_b.pop_front();
        chk("b_captured", 32'(cap_b), 32'(e_b.cap));
        chk("b_err_count", 32'(err_b), 32'(e_b.err));
        chk("b_first_fail", 32'(ffi_b), 32'(e_b.ffi));
        chk("b_pass", 32'(pass_b), 32'(e_b.pass));
        chk("b_abc_last", 32'(abc_b), 32'(7));
        chk("b_busy_at_done", 32'(busy_b), 32'(0));
        chk("b_done_cycle", 32'(cyc), 32'(e_b.done_cyc));
      end
    end
    prev_done_b = done_b;
  end

  task automatic check_a_zero(input string tag);
    chk({tag, "_abc"}, 32'(abc_a), 32'(0));
    chk({tag, "_busy"}, 32'(busy_a), 32'(0));
    chk({tag, "_done"}, 32'(done_a), 32'(0));
    chk({tag, "_pass"}, 32'(pass_a), 32'(0));
    chk({tag, "_err"}, 32'(err_a), 32'(0));
    chk({tag, "_ffi"}, 32'(ffi_a), 32'(0));
    chk({tag, "_cap"}, 32'(cap_a), 32'(0));
  endtask

  task automatic wait_done(input bit sel, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (sel ? done_b : done_a) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk({tag, "_done_timeout"}, 32'(0), 32'(1));
  endtask

  // One sweep on the selected instance; noisy adds random start pulses mid-sweep.
  task automatic sweep(input bit sel, input logic [7:0] tt, input bit noisy);
    int  s, settle, span;
    bit  seen;
    settle = sel ? 0 : 2;
    span   = 8 * (settle + 2);
    @(negedge clk);
    if (sel) begin tt_b = tt; start_b = 1'b1; end
    else     begin tt_a = tt; start_a = 1'b1; end
    s = cyc + 1;
    if (sel) q_b.push_back(model(tt, s, settle));
    else     q_a.push_back(model(tt, s, settle));
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (sel ? done_b : done_a) begin
        seen = 1;
        break;
      end
      if (noisy && cyc < s + span - 2) begin
        if (sel) start_b = 1'($urandom % 2);
        else     start_a = 1'($urandom % 2);
      end else begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (!seen) chk("sweep_done_timeout", 32'(0), 32'(1));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit found;
    int s;
    // Reset state
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    chk("reset_b_done", 32'(done_b), 32'(0));
    chk("reset_b_cap", 32'(cap_b), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Correct majority, stuck-at-0 and inverted blocks
    sweep(1'b0, maj_tt(), 1'b0);
    sweep(1'b0, 8'h00, 1'b0);
    sweep(1'b0, ~maj_tt(), 1'b0);

    // Reset in the middle of a sweep, then a clean sweep
    @(negedge clk);
    tt_a = maj_tt();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (abc_a == 3'd5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_reached_5", 32'(found), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    check_a_zero("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_idle_busy", 32'(busy_a), 32'(0));
    sweep(1'b0, maj_tt(), 1'b0);

    // Start held high: sweep unaffected, then an immediate restart from DONE
    @(negedge clk);
    tt_a = maj_tt();
    start_a = 1'b1;
    s = cyc + 1;
    q_a.push_back(model(maj_tt(), s, 2));
    @(negedge clk);
    wait_done(1'b0, "held");
    q_a.push_back(model(maj_tt(), cyc + 1, 2));
    @(negedge clk);
    chk("held_restart_done", 32'(done_a), 32'(0));
    chk("held_restart_busy", 32'(busy_a), 32'(1));
    start_a = 1'b0;
    wait_done(1'b0, "held2");
    @(negedge clk);

    // Random blocks with stray start pulses while busy
    for (int r = 0; r < 6; r++) begin
      sweep(1'b0, 8'($urandom), 1'b1);
    end

    // Zero settle instance
    sweep(1'b1, maj_tt(), 1'b0);
    sweep(1'b1, 8'h00, 1'b0);
    for (int r = 0; r < 3; r++) begin
      sweep(1'b1, 8'($urandom), 1'b1);
    end

    repeat (3) @(negedge clk);
    chk("q_a_drained", 32'(q_a.size()), 32'(0));
    chk("q_b_drained", 32'(q_b.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
